// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, register index
// and the load-use dependence test.
package hazard_unit_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hazard_state_t;

    // $zero never carries a real dependence, so a load targeting it cannot stall.
    function automatic logic load_use(input logic memread, input regbits_t rd,
                                      input regbits_t rs, input regbits_t rt);
        return memread && (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit handshake bundle: pipeline status in, latch enables/flushes,
// halt and performance counters out.
interface hazard_unit_if
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_ren;
    logic             mem_wen;
    logic             ex_memread;
    regbits_t         ex_rd;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             id_jump;
    logic             mem_branch_taken;
    logic             mem_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hu (
        input  ihit, dhit, mem_ren, mem_wen, ex_memread, ex_rd, id_rs, id_rt,
               id_jump, mem_branch_taken, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, flush_cnt
    );

    modport tb (
        output ihit, dhit, mem_ren, mem_wen, ex_memread, ex_rd, id_rs, id_rt,
               id_jump, mem_branch_taken, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: combinational latch enables/flushes from cache
// handshakes, load-use, branch/jump and halt; registered state and counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16  // must match the CNT_W of the connected interface
) (
    input  logic        CLK,
    input  logic        RST,
    hazard_unit_if.hu   hif
);
    hazard_state_t state_q, state_d;
    logic          halted_q, halted_d;
    logic          dstall, lu;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush;
    logic          pc_en_o, any_flush_o;
    logic          stall_inc, flush_inc;

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;

        // In DWAIT the outstanding access is resolved by dhit alone.
        dstall = (state_q == DWAIT) ? ~hif.dhit
                                    : ((hif.mem_ren | hif.mem_wen) & ~hif.dhit);
        lu     = load_use(hif.ex_memread, hif.ex_rd, hif.id_rs, hif.id_rt);

        if (state_q != HALT) begin
            if (hif.mem_halt && !dstall) begin
                state_d = HALT;
            end else if (dstall) begin
                state_d = DWAIT;
            end else begin
                state_d = RUN;
                if (hif.ihit) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    if (hif.mem_branch_taken) begin
                        // Flushing ID also kills any dependent load-use consumer.
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (hif.id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
            end
        end

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign pc_en_o         = pc_en & ~RST;
    assign hif.pc_en       = pc_en_o;
    assign hif.ifid_en     = ifid_en & ~RST;
    assign hif.idex_en     = idex_en & ~RST;
    assign hif.exmem_en    = exmem_en & ~RST;
    assign hif.memwb_en    = memwb_en & ~RST;
    assign hif.ifid_flush  = ifid_flush & ~RST;
    assign hif.idex_flush  = idex_flush & ~RST;
    assign hif.exmem_flush = exmem_flush & ~RST;
    assign hif.halted      = halted_q;

    assign any_flush_o = (ifid_flush | idex_flush | exmem_flush) & ~RST;
    assign stall_inc   = (state_q != HALT) & ~pc_en_o;
    assign flush_inc   = any_flush_o;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (hif.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (hif.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a 16-bit instance for function, plus a 4-bit
// instance fed the same inputs to exercise counter saturation.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 CLK = ~CLK;

    hazard_unit_if #(.CNT_W(16)) hif ();
    hazard_unit_if #(.CNT_W(4))  hif4 ();

    hazard_unit #(.CNT_W(16)) dut (.CLK(CLK), .RST(RST), .hif(hif.hu));
    hazard_unit #(.CNT_W(4))  dut4 (.CLK(CLK), .RST(RST), .hif(hif4.hu));

    assign hif4.ihit             = hif.ihit;
    assign hif4.dhit             = hif.dhit;
    assign hif4.mem_ren          = hif.mem_ren;
    assign hif4.mem_wen          = hif.mem_wen;
    assign hif4.ex_memread       = hif.ex_memread;
    assign hif4.ex_rd            = hif.ex_rd;
    assign hif4.id_rs            = hif.id_rs;
    assign hif4.id_rt            = hif.id_rt;
    assign hif4.id_jump          = hif.id_jump;
    assign hif4.mem_branch_taken = hif.mem_branch_taken;
    assign hif4.mem_halt         = hif.mem_halt;

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en};
    assign fl = {hif.ifid_flush, hif.idex_flush, hif.exmem_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic ihit);
        hif.ihit = ihit;  hif.dhit = 1'b0;  hif.mem_ren = 1'b0;  hif.mem_wen = 1'b0;
        hif.ex_memread = 1'b0;  hif.ex_rd = '0;  hif.id_rs = '0;  hif.id_rt = '0;
        hif.id_jump = 1'b0;  hif.mem_branch_taken = 1'b0;  hif.mem_halt = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] exp_en, input logic [2:0] exp_fl);
        #1;
        chk({tag, "_en"}, 32'(en), 32'(exp_en));
        chk({tag, "_fl"}, 32'(fl), 32'(exp_fl));
    endtask

    initial begin
        // Reset: enables forced low even with ihit asserted.
        idle(1'b1);
        #1;
        chk_out("rst", 5'b00000, 3'b000);
        tick();
        chk("rst_halted", 32'(hif.halted), 0);
        chk("rst_stall", 32'(hif.stall_cnt), 0);
        chk("rst_flush", 32'(hif.flush_cnt), 0);
        RST = 1'b0;
        chk_out("run_free", 5'b11111, 3'b000);
        tick();

        // Load-use on rt: one-cycle bubble.
        hif.ex_memread = 1'b1;  hif.ex_rd = 5'd5;  hif.id_rt = 5'd5;
        chk_out("lu", 5'b00111, 3'b010);
        tick();
        hif.ex_memread = 1'b0;  hif.ex_rd = '0;
        chk_out("lu_after", 5'b11111, 3'b000);
        chk("lu_stall", 32'(hif.stall_cnt), 1);
        chk("lu_flush", 32'(hif.flush_cnt), 1);

        // Load into $zero: no dependence.
        hif.ex_memread = 1'b1;  hif.id_rs = '0;  hif.id_rt = '0;
        chk_out("lu_r0", 5'b11111, 3'b000);
        tick();
        hif.ex_memread = 1'b0;
        chk("lu_r0_stall", 32'(hif.stall_cnt), 1);

        // Data miss for 3 cycles, then dhit advances.
        hif.mem_ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("dmiss%0d", i), 5'b00000, 3'b000);
            tick();
        end
        chk("dmiss_stall", 32'(hif.stall_cnt), 4);
        hif.dhit = 1'b1;
        chk_out("dhit", 5'b11111, 3'b000);
        tick();
        hif.mem_ren = 1'b0;  hif.dhit = 1'b0;
        chk_out("dhit_run", 5'b11111, 3'b000);
        chk("dhit_stall", 32'(hif.stall_cnt), 4);

        // Branch beats load-use, branch beats jump.
        hif.mem_branch_taken = 1'b1;
        hif.ex_memread = 1'b1;  hif.ex_rd = 5'd7;  hif.id_rs = 5'd7;
        chk_out("br_lu", 5'b11111, 3'b111);
        tick();
        hif.ex_memread = 1'b0;  hif.id_jump = 1'b1;
        chk_out("br_j", 5'b11111, 3'b111);
        tick();
        hif.mem_branch_taken = 1'b0;
        chk_out("jump", 5'b11111, 3'b100);
        tick();
        hif.id_jump = 1'b0;
        chk("br_flush", 32'(hif.flush_cnt), 4);
        chk("br_stall", 32'(hif.stall_cnt), 4);

        // icache miss holds everything even with a taken branch.
        hif.ihit = 1'b0;  hif.mem_branch_taken = 1'b1;
        chk_out("imiss_br", 5'b00000, 3'b000);
        tick();
        idle(1'b1);
        chk("imiss_stall", 32'(hif.stall_cnt), 5);

        // Asynchronous reset mid-DWAIT.
        hif.mem_ren = 1'b1;
        tick();
        chk("dw_stall", 32'(hif.stall_cnt), 6);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_stall", 32'(hif.stall_cnt), 0);
        chk("arst_flush", 32'(hif.flush_cnt), 0);
        RST = 1'b0;
        hif.mem_ren = 1'b0;
        chk_out("arst_run", 5'b11111, 3'b000);
        tick();

        // Halt during a data miss waits for dhit, then halts.
        hif.mem_halt = 1'b1;  hif.mem_ren = 1'b1;
        chk_out("halt_miss", 5'b00000, 3'b000);
        tick();
        chk("halt_miss_h", 32'(hif.halted), 0);
        hif.dhit = 1'b1;
        chk_out("halt_dhit", 5'b00000, 3'b000);
        tick();
        chk("halted", 32'(hif.halted), 1);
        chk("halt_stall", 32'(hif.stall_cnt), 2);
        idle(1'b1);
        hif.mem_branch_taken = 1'b1;
        chk_out("halt_hold", 5'b00000, 3'b000);
        tick();
        chk("halt_stall2", 32'(hif.stall_cnt), 2);
        chk("halt_keep", 32'(hif.halted), 1);

        // Reset out of HALT, then saturation with ihit low.
        RST = 1'b1;
        #1;
        chk("arst_halted", 32'(hif.halted), 0);
        RST = 1'b0;
        idle(1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat16_stall", 32'(hif.stall_cnt), 20);
        chk("sat4_stall", 32'(hif4.stall_cnt), 15);
        chk("sat4_flush", 32'(hif4.flush_cnt), 0);
        hif.ihit = 1'b1;
        chk_out("post_sat", 5'b11111, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
